// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the switch debouncer bank.
//   - MODE_SPDT / MODE_SPST : contact arrangement selectors for the MODE
//                             parameter of switch_debounce_bank / debounce_ch.
//   - cnt_w_min()           : smallest counter width able to hold the value
//                             STABLE_CNT-1 (at least 1 bit).
// -----------------------------------------------------------------------------
package debounce_pkg;

  // Changeover contact: NO and NC both wired, break-before-make.
  localparam int MODE_SPDT = 0;
  // Single contact: only NO is wired, NC is ignored.
  localparam int MODE_SPST = 1;

  // Smallest w with 2**w > stable_cnt-1. The bound on w keeps the shift
  // inside a 32-bit int for absurd arguments.
  function automatic int cnt_w_min(input int stable_cnt);
    int w;
    w = 1;
    while ((w < 31) && ((1 << w) <= (stable_cnt - 1))) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : debounce_pkg

// File: rtl/switch_debounce_bank_if.sv
// -----------------------------------------------------------------------------
// switch_debounce_bank_if
//   Bundles the per-channel contact inputs and the debounced outputs of
//   switch_debounce_bank. Clock and reset are kept as plain ports on the
//   design itself.
//
//   Signals (all N_CH wide unless noted):
//     NO      : normally-open contacts, active-low (0 = pressed), asynchronous
//     NC      : normally-closed contacts, active-low (0 = released), asynchronous
//     CLR_ERR : 1 bit, synchronous clear of every ERR bit
//     Q       : debounced level (1 = pressed)
//     RISE    : one-cycle pulse when Q goes 0->1
//     FALL    : one-cycle pulse when Q goes 1->0
//     TQ      : toggles on every RISE
//     ERR     : sticky contact-fault flag (both contacts active together)
//
//   Modports:
//     master : the side that owns the switches (drives NO/NC/CLR_ERR)
//     slave  : the debouncer bank
// -----------------------------------------------------------------------------
interface switch_debounce_bank_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0] NO;
  logic [N_CH-1:0] NC;
  logic            CLR_ERR;
  logic [N_CH-1:0] Q;
  logic [N_CH-1:0] RISE;
  logic [N_CH-1:0] FALL;
  logic [N_CH-1:0] TQ;
  logic [N_CH-1:0] ERR;

  modport master (
    output NO,
    output NC,
    output CLR_ERR,
    input  Q,
    input  RISE,
    input  FALL,
    input  TQ,
    input  ERR
  );

  modport slave (
    input  NO,
    input  NC,
    input  CLR_ERR,
    output Q,
    output RISE,
    output FALL,
    output TQ,
    output ERR
  );

endinterface : switch_debounce_bank_if

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
//   One debouncer channel: two-flop synchroniser per contact, candidate
//   decoding, stability counter, and the registered Q / RISE / FALL / TQ / ERR
//   outputs.
//
//   Parameters:
//     MODE       : MODE_SPDT (NO+NC) or MODE_SPST (NO only)
//     STABLE_CNT : consecutive cycles the candidate must differ from Q
//                  before Q takes it (>= 1)
//     CNT_W      : counter width, 2**CNT_W > STABLE_CNT-1
//
//   Ports:
//     clk_i      : clock
//     rst_i      : synchronous active-high reset
//     no_i       : raw NO contact, active-low, asynchronous
//     nc_i       : raw NC contact, active-low, asynchronous
//     clr_err_i  : synchronous clear of err_o (a fault in the same cycle wins)
//     q_o        : debounced level, 1 = pressed
//     rise_o     : one-cycle pulse in the first cycle q_o shows 1
//     fall_o     : one-cycle pulse in the first cycle q_o shows 0
//     tq_o       : toggles on every rise
//     err_o      : sticky "both contacts active" flag (SPDT only)
// -----------------------------------------------------------------------------
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int MODE       = MODE_SPDT,
  parameter int STABLE_CNT = 50000,
  parameter int CNT_W      = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic no_i,
  input  logic nc_i,
  input  logic clr_err_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic tq_o,
  output logic err_o
);

  // Count value at which the next differing cycle commits the candidate.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  // Synchroniser stages; they idle at 1, the inactive contact level.
  logic no_s1_q;
  logic no_s2_q;
  logic nc_s1_q;
  logic nc_s2_q;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             q_q;
  logic             q_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;
  logic             tq_q;
  logic             tq_d;
  logic             err_q;
  logic             err_d;

  logic             cand;
  logic             fault;

  // ---- Stage 0/1: two-flop synchroniser on each raw contact ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      no_s1_q <= 1'b1;
      no_s2_q <= 1'b1;
      nc_s1_q <= 1'b1;
      nc_s2_q <= 1'b1;
    end else begin
      no_s1_q <= no_i;
      no_s2_q <= no_s1_q;
      nc_s1_q <= nc_i;
      nc_s2_q <= nc_s1_q;
    end
  end

  // ---- Candidate decode from the synchronised contacts ----
  // In SPDT mode the in-flight (1,1) and illegal (0,0) states both hold the
  // current level, so a slow armature never resets Q by itself.
  always_comb begin
    cand  = q_q;
    fault = 1'b0;
    if (MODE == MODE_SPST) begin
      cand = ~no_s2_q;
    end else begin
      case ({no_s2_q, nc_s2_q})
        2'b01:   cand = 1'b1;
        2'b10:   cand = 1'b0;
        2'b00: begin
          cand  = q_q;
          fault = 1'b1;
        end
        default: cand = q_q;
      endcase
    end
  end

  // ---- Stability counter and output next-state ----
  // One cycle of agreement with Q discards any partial count. The counter
  // stops at CNT_LAST, so it can never wrap.
  always_comb begin
    cnt_d  = cnt_q;
    q_d    = q_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    tq_d   = tq_q;
    err_d  = err_q;

    if (cand == q_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      q_d    = cand;
      rise_d = cand;
      fall_d = ~cand;
      tq_d   = tq_q ^ cand;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A fault seen in the same cycle as a clear request must stay visible.
    if (clr_err_i) begin
      err_d = 1'b0;
    end
    if (fault) begin
      err_d = 1'b1;
    end
  end

  // ---- Stage 2: registered level, pulses, toggle and fault flag ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      q_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      tq_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      tq_q   <= tq_d;
      err_q  <= err_d;
    end
  end

  assign q_o    = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign tq_o   = tq_q;
  assign err_o  = err_q;

endmodule : debounce_ch

// File: rtl/switch_debounce_bank.sv
// -----------------------------------------------------------------------------
// switch_debounce_bank
//   Multi-channel contact debouncer. Every channel is an independent
//   debounce_ch instance with its own synchroniser and counter; only the
//   clock, reset and error-clear are shared.
//
//   Parameters:
//     N_CH       : number of channels
//     MODE       : MODE_SPDT (0, NO+NC contacts) or MODE_SPST (1, NO only)
//     STABLE_CNT : stable cycles required before Q changes (>= 1)
//     CNT_W      : counter width, 2**CNT_W > STABLE_CNT-1
//                  (debounce_pkg::cnt_w_min gives the minimum)
//
//   Ports:
//     CLKIN : sole clock
//     RST   : synchronous active-high reset
//     bus   : switch_debounce_bank_if slave modport
//             (NO, NC, CLR_ERR in; Q, RISE, FALL, TQ, ERR out)
// -----------------------------------------------------------------------------
module switch_debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int MODE       = MODE_SPDT,
  parameter int STABLE_CNT = 50000,
  parameter int CNT_W      = 16
) (
  input  logic                 CLKIN,
  input  logic                 RST,
  switch_debounce_bank_if.slave bus
);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    debounce_ch #(
      .MODE       (MODE),
      .STABLE_CNT (STABLE_CNT),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk_i     (CLKIN),
      .rst_i     (RST),
      .no_i      (bus.NO[ch]),
      .nc_i      (bus.NC[ch]),
      .clr_err_i (bus.CLR_ERR),
      .q_o       (bus.Q[ch]),
      .rise_o    (bus.RISE[ch]),
      .fall_o    (bus.FALL[ch]),
      .tq_o      (bus.TQ[ch]),
      .err_o     (bus.ERR[ch])
    );
  end

endmodule : switch_debounce_bank

// File: tb/tb_switch_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce_bank
//   Two instances: u_dut0 (SPDT, STABLE_CNT=4, minimum counter width) and
//   u_dut1 (SPST, STABLE_CNT=1). Inputs change 1 time unit after a rising
//   edge; outputs are sampled 1 time unit after the following rising edge,
//   so "edge k" below means the k-th edge after the inputs were applied.
// -----------------------------------------------------------------------------
module tb_switch_debounce_bank;
  import debounce_pkg::*;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  switch_debounce_bank_if #(.N_CH(4)) if0 ();
  switch_debounce_bank_if #(.N_CH(4)) if1 ();

  switch_debounce_bank #(
    .N_CH       (4),
    .MODE       (MODE_SPDT),
    .STABLE_CNT (4),
    .CNT_W      (cnt_w_min(4))
  ) u_dut0 (
    .CLKIN (clk),
    .RST   (rst0),
    .bus   (if0)
  );

  switch_debounce_bank #(
    .N_CH       (4),
    .MODE       (MODE_SPST),
    .STABLE_CNT (1),
    .CNT_W      (cnt_w_min(1))
  ) u_dut1 (
    .CLKIN (clk),
    .RST   (rst1),
    .bus   (if1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] no;
    logic [3:0] nc;
    logic       clr;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] tq;
    logic [3:0] err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic [3:0] no, input logic [3:0] nc,
                     input logic cl, input logic [3:0] q, input logic [3:0] ri,
                     input logic [3:0] fa, input logic [3:0] tq, input logic [3:0] er);
    vecs.push_back('{r, no, nc, cl, q, ri, fa, tq, er});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic chk_all(input bit which, input string tag, input logic [3:0] q,
                         input logic [3:0] ri, input logic [3:0] fa,
                         input logic [3:0] tq, input logic [3:0] er);
    if (which) begin
      chk({tag, " Q"},    if1.Q,    q);
      chk({tag, " RISE"}, if1.RISE, ri);
      chk({tag, " FALL"}, if1.FALL, fa);
      chk({tag, " TQ"},   if1.TQ,   tq);
      chk({tag, " ERR"},  if1.ERR,  er);
    end else begin
      chk({tag, " Q"},    if0.Q,    q);
      chk({tag, " RISE"}, if0.RISE, ri);
      chk({tag, " FALL"}, if0.FALL, fa);
      chk({tag, " TQ"},   if0.TQ,   tq);
      chk({tag, " ERR"},  if0.ERR,  er);
    end
  endtask

  task automatic drive0(input logic [3:0] no, input logic [3:0] nc, input logic cl);
    if0.NO      = no;
    if0.NC      = nc;
    if0.CLR_ERR = cl;
  endtask

  initial begin
    logic b;

    rst0        = 1'b1;
    rst1        = 1'b1;
    if0.NO      = 4'b1111;
    if0.NC      = 4'b0000;
    if0.CLR_ERR = 1'b0;
    if1.NO      = 4'b1111;
    if1.NC      = 4'b0000;
    if1.CLR_ERR = 1'b0;

    // Reset, idle, then ch0 press and ch2 press / release / press.
    repeat (3) add(1'b1, 4'b1111, 4'b0000, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (3) add(1'b0, 4'b1111, 4'b0000, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (5) add(1'b0, 4'b1110, 4'b0001, 1'b0, 4'b0000, 4'h0, 4'h0, 4'b0000, 4'h0);
    add(1'b0, 4'b1110, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'h0, 4'b0001, 4'h0);
    add(1'b0, 4'b1110, 4'b0001, 1'b0, 4'b0001, 4'h0,    4'h0, 4'b0001, 4'h0);
    repeat (5) add(1'b0, 4'b1010, 4'b0101, 1'b0, 4'b0001, 4'h0, 4'h0, 4'b0001, 4'h0);
    add(1'b0, 4'b1010, 4'b0101, 1'b0, 4'b0101, 4'b0100, 4'h0, 4'b0101, 4'h0);
    add(1'b0, 4'b1010, 4'b0101, 1'b0, 4'b0101, 4'h0,    4'h0, 4'b0101, 4'h0);
    repeat (5) add(1'b0, 4'b1110, 4'b0001, 1'b0, 4'b0101, 4'h0, 4'h0, 4'b0101, 4'h0);
    add(1'b0, 4'b1110, 4'b0001, 1'b0, 4'b0001, 4'h0, 4'b0100, 4'b0101, 4'h0);
    add(1'b0, 4'b1110, 4'b0001, 1'b0, 4'b0001, 4'h0, 4'h0,    4'b0101, 4'h0);
    repeat (5) add(1'b0, 4'b1010, 4'b0101, 1'b0, 4'b0001, 4'h0, 4'h0, 4'b0101, 4'h0);
    add(1'b0, 4'b1010, 4'b0101, 1'b0, 4'b0101, 4'b0100, 4'h0, 4'b0001, 4'h0);
    add(1'b0, 4'b1010, 4'b0101, 1'b0, 4'b0101, 4'h0,    4'h0, 4'b0001, 4'h0);

    foreach (vecs[i]) begin
      rst0 = vecs[i].rst;
      drive0(vecs[i].no, vecs[i].nc, vecs[i].clr);
      tick();
      chk_all(1'b0, $sformatf("vec%0d", i), vecs[i].q, vecs[i].rise,
              vecs[i].fall, vecs[i].tq, vecs[i].err);
    end

    // Bounce on ch1: NO[1] alternates in runs of 2 for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      b = (((i / 2) % 2) == 1);
      drive0({1'b1, 1'b0, b, 1'b0}, {1'b0, 1'b1, ~b, 1'b1}, 1'b0);
      tick();
      chk($sformatf("bounce%0d Q", i),    if0.Q,    4'b0101);
      chk($sformatf("bounce%0d RISE", i), if0.RISE, 4'b0000);
    end
    drive0(4'b1000, 4'b0111, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk_all(1'b0, $sformatf("settle%0d", e), 4'b0101, 4'h0, 4'h0, 4'b0001, 4'h0);
    end
    tick();
    chk_all(1'b0, "settle6", 4'b0111, 4'b0010, 4'h0, 4'b0011, 4'h0);
    tick();
    chk_all(1'b0, "settle7", 4'b0111, 4'h0, 4'h0, 4'b0011, 4'h0);

    // ch3 pressed for STABLE_CNT-1 cycles only: must never reach Q.
    drive0(4'b0000, 4'b1111, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      if (e == 4) drive0(4'b1000, 4'b0111, 1'b0);
      tick();
      chk_all(1'b0, $sformatf("glitch%0d", e), 4'b0111, 4'h0, 4'h0, 4'b0011, 4'h0);
    end

    // Contact fault on ch3 (NO and NC both active) for 3 cycles.
    drive0(4'b0000, 4'b0111, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      if (e == 4) drive0(4'b1000, 4'b0111, 1'b0);
      tick();
      chk_all(1'b0, $sformatf("fault%0d", e), 4'b0111, 4'h0, 4'h0, 4'b0011,
              (e >= 3) ? 4'b1000 : 4'b0000);
    end
    drive0(4'b1000, 4'b0111, 1'b1);
    tick();
    chk("clr ERR", if0.ERR, 4'b0000);
    drive0(4'b1000, 4'b0111, 1'b0);
    tick();
    chk("after clr ERR", if0.ERR, 4'b0000);

    // Fault while CLR_ERR is held: set wins.
    drive0(4'b0000, 4'b0111, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("faultclr%0d ERR", e), if0.ERR, (e >= 3) ? 4'b1000 : 4'b0000);
      chk($sformatf("faultclr%0d Q", e),   if0.Q,   4'b0111);
    end
    drive0(4'b1000, 4'b0111, 1'b0);
    for (int e = 5; e <= 9; e++) begin
      tick();
      chk($sformatf("faultclr%0d ERR", e), if0.ERR, 4'b1000);
    end
    drive0(4'b1000, 4'b0111, 1'b1);
    tick();
    chk("clr2 ERR", if0.ERR, 4'b0000);
    drive0(4'b1000, 4'b0111, 1'b0);

    // Reset in the middle of ch3 qualification, with ch0-2 held pressed.
    drive0(4'b0000, 4'b1111, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk_all(1'b0, $sformatf("rstmid%0d", e), 4'b0111, 4'h0, 4'h0, 4'b0011, 4'h0);
    end
    rst0 = 1'b1;
    tick();
    chk_all(1'b0, "rstmid4", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst0 = 1'b0;
    for (int e = 5; e <= 9; e++) begin
      tick();
      chk_all(1'b0, $sformatf("rstmid%0d", e), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    tick();
    chk_all(1'b0, "rstmid10", 4'b1111, 4'b1111, 4'h0, 4'b1111, 4'h0);
    tick();
    chk_all(1'b0, "rstmid11", 4'b1111, 4'h0, 4'h0, 4'b1111, 4'h0);

    // SPST, STABLE_CNT=1: NC floating low is ignored.
    tick();
    chk_all(1'b1, "m1rst", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst1 = 1'b0;
    repeat (3) tick();
    chk_all(1'b1, "m1idle", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    if1.NO = 4'b1110;
    tick();
    chk_all(1'b1, "m1press1", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    chk_all(1'b1, "m1press2", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    chk_all(1'b1, "m1press3", 4'b0001, 4'b0001, 4'h0, 4'b0001, 4'h0);
    tick();
    chk_all(1'b1, "m1press4", 4'b0001, 4'h0, 4'h0, 4'b0001, 4'h0);
    if1.NO = 4'b1111;
    tick();
    tick();
    chk_all(1'b1, "m1rel2", 4'b0001, 4'h0, 4'h0, 4'b0001, 4'h0);
    tick();
    chk_all(1'b1, "m1rel3", 4'h0, 4'h0, 4'b0001, 4'b0001, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_switch_debounce_bank

// File: doc/switch_debounce_bank.md
# switch_debounce_bank

Parametrised multi-channel contact debouncer: the next generation of the lab bounceless-switch latch. Each channel synchronises raw active-low switch contacts to `CLKIN`, qualifies them with a stability counter, and produces a clean level, one-cycle edge pulses, a toggle (T flip-flop) output and a sticky contact-fault flag. It sits between board pushbuttons or slide switches and any synchronous logic that consumes user input.

## Interface
- `N_CH`, 4: number of independent channels.
- `MODE`, 0: 0 = SPDT (NO and NC contacts, break-before-make); 1 = SPST (NO contact only, NC ignored).
- `STABLE_CNT`, 50000: consecutive stable cycles required before the output changes; ≥1.
- `CNT_W`, 16: counter width; must satisfy 2^CNT_W > STABLE_CNT-1.

Ports:
- `CLKIN`  in  1  sole clock.
- `RST`  in  1  synchronous, active-high reset.
- `NO`  in  N_CH  normally-open contacts, active-low (0 = pressed), asynchronous.
- `NC`  in  N_CH  normally-closed contacts, active-low (0 = released), asynchronous.
- `CLR_ERR`  in  1  synchronous clear of all `ERR` bits.
- `Q`  out  N_CH  debounced level (1 = pressed).
- `RISE`  out  N_CH  one-cycle pulse on a 0→1 `Q` change.
- `FALL`  out  N_CH  one-cycle pulse on a 1→0 `Q` change.
- `TQ`  out  N_CH  toggles on every `RISE`.
- `ERR`  out  N_CH  sticky: both contacts seen active together (MODE 0 only).

## Operation
- Synchroniser: two flip-flops per contact. Both stages reset to 1, which is the idle/inactive contact level.
- Candidate value per channel, from the synchronised `no_s` and `nc_s`:
  - MODE 0:
    - `no_s=0, nc_s=1` → 1.
    - `no_s=1, nc_s=0` → 0.
    - `1,1` (armature in flight) → hold `Q`.
    - `0,0` (illegal) → hold `Q` and set `ERR`.
  - MODE 1: candidate = `~no_s`.
- Counter, evaluated per clock edge:
  - If candidate == `Q`: cnt←0.
  - Else if cnt == STABLE_CNT-1: `Q`←candidate, cnt←0.
  - Else: cnt←cnt+1.
  - Any single cycle of candidate == `Q` restarts qualification.
- Edge outputs:
  - `RISE` and `FALL` are registered and asserted in the same cycle `Q` first shows its new value. They last exactly one cycle.
  - `TQ` flips on the edge where `RISE` is asserted.
- `ERR` handling:
  - Set on any edge where `no_s=0` and `nc_s=0`.
  - Cleared by `CLR_ERR` or `RST`.
  - Set has priority over clear in the same cycle.
- Channels are fully independent; no shared counter.

## Timing
- Reset values: `Q`=0, `RISE`=0, `FALL`=0, `TQ`=0, `ERR`=0, counters 0, synchroniser stages 1.
  - `RST` mid-qualification discards the count.
  - No edge pulse is generated by reset itself.
- Latency: a contact change present before edge 1 and held stable updates `Q`, with `RISE`/`FALL`, at edge 2+STABLE_CNT.
  - Edges 1–2: synchroniser.
  - Edge 3: first count.
  - STABLE_CNT=1 → `Q` updates at edge 3.
- A glitch shorter than STABLE_CNT synchronised cycles never reaches `Q`.
- Counter never exceeds STABLE_CNT-1; no wrap.
- Press and release events are separated by at least STABLE_CNT cycles, so `RISE` and `FALL` never coincide on one channel.

## Structure
- Shared package `debounce_pkg`: `MODE_SPDT`=0 and `MODE_SPST`=1 constants, plus a function that computes the minimum `CNT_W` from `STABLE_CNT`.
- One sub-module `debounce_ch`: synchroniser, candidate logic, counter, `Q`/`RISE`/`FALL`/`TQ`/`ERR` for a single channel.
- Top level generates `N_CH` instances and fans out `CLKIN`, `RST` and `CLR_ERR`.

## Test plan
All scenarios use STABLE_CNT=4, N_CH=4 unless stated.
- Clean press, MODE 0: ch0 `NO`=0, `NC`=1 applied before edge 1 → `Q[0]`=1, `RISE[0]`=1 for one cycle at edge 6, `TQ[0]`=1. Other channels stay 0.
- Bounce rejection: `NO[1]` toggles 0/1 every 2 cycles for 20 cycles, then holds 0 with `NC[1]`=1 → no `RISE` during bouncing; `RISE[1]` fires exactly 6 edges after the final stable value.
- Release and toggle: press, release, press on ch2 →
  - Pulse sequence: `RISE`, `FALL`, `RISE`, each one cycle.
  - `TQ[2]` sequence: 0→1→1→0.
- Contact fault: ch3 `NO`=0 and `NC`=0 for 3 cycles →
  - `ERR[3]`=1 from edge 3, and it persists after the contacts recover.
  - `Q[3]` unchanged.
  - `CLR_ERR` pulse clears it; with `CLR_ERR` held during the fault, `ERR` still sets.
- Reset mid-qualification: stable press, `RST` at edge 4 → `Q`=0, no pulse; qualification restarts after `RST` deasserts, with `Q` updating 4 count edges later.
- MODE 1, STABLE_CNT=1: `NO[0]`=0 with `NC` floating at 0 → `Q[0]`=1 at edge 3, `ERR` stays 0.
